// File: rtl/union_find_vertex.sv
// union_find_vertex: per-vertex union-find unit (syndrome load, one-step cluster growth, min-root merge)
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   stage                      global stage: 0 IDLE, 1 MEASUREMENT_LOADING, 2 GROW_BOUNDARY, 3 MERGE, 4..7 reserved
//   measurement                syndrome bit loaded in MEASUREMENT_LOADING
//   neighbor_fully_grown       per-link fully-grown flag
//   neighbor_old_root          far-side root per link, slice i = [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   neighbor_is_odd_cluster    per-link odd flag
//   neighbor_increase          one-cycle grow strobe per link
//   old_root_out, root         current root (same register)
//   is_odd_cluster             vertex belongs to an odd cluster
//   busy                       root or odd flag changed on the last update
//   root_change_count          saturating count of MERGE root changes (only with UNION_FIND_VERTEX_ROOT_COUNT_EN)
module union_find_vertex #(
  parameter int unsigned ADDRESS_WIDTH  = 12,
  parameter int unsigned NEIGHBOR_COUNT = 4,
  parameter int unsigned ADDRESS        = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [2:0]                              stage,
  input  logic                                    measurement,
  input  logic [NEIGHBOR_COUNT-1:0]               neighbor_fully_grown,
  input  logic [NEIGHBOR_COUNT*ADDRESS_WIDTH-1:0] neighbor_old_root,
  input  logic [NEIGHBOR_COUNT-1:0]               neighbor_is_odd_cluster,
  output logic [NEIGHBOR_COUNT-1:0]               neighbor_increase,
  output logic [ADDRESS_WIDTH-1:0]                old_root_out,
  output logic                                    is_odd_cluster,
  output logic [ADDRESS_WIDTH-1:0]                root,
  output logic                                    busy
`ifdef UNION_FIND_VERTEX_ROOT_COUNT_EN
  ,
  output logic [7:0]                              root_change_count
`endif
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_GROW  = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [ADDRESS_WIDTH-1:0] OWN = ADDRESS_WIDTH'(ADDRESS);
  logic [ADDRESS_WIDTH-1:0]  root_q, root_d, cand;
  logic                      odd_q, odd_d, busy_q, busy_d;
  logic [NEIGHBOR_COUNT-1:0] inc_q, inc_d;
  logic [2:0]                prev_stage_q;
  always_comb begin
    cand = '1;
    for (int i = 0; i < int'(NEIGHBOR_COUNT); i++)
      if (neighbor_fully_grown[i] && neighbor_old_root[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] < cand)
        cand = neighbor_old_root[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end
  // cand is only meaningful with at least one grown link; the '1 default never wins then
  always_comb begin
    root_d = root_q;
    odd_d  = odd_q;
    inc_d  = '0;
    busy_d = 1'b0;
    if (stage == ST_LOAD) begin
      root_d = OWN;
      odd_d  = measurement;
    end else if (stage == ST_GROW) begin
      inc_d = (stage != prev_stage_q) ? ({NEIGHBOR_COUNT{odd_q}} & ~neighbor_fully_grown) : '0;
    end else if (stage == ST_MERGE) begin
      root_d = (|neighbor_fully_grown && cand < root_q) ? cand : root_q;
      odd_d  = odd_q | |(neighbor_fully_grown & neighbor_is_odd_cluster);
      busy_d = (root_d != root_q) | (odd_d != odd_q);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      root_q       <= OWN;
      odd_q        <= 1'b0;
      inc_q        <= '0;
      busy_q       <= 1'b0;
      prev_stage_q <= ST_IDLE;
    end else begin
      root_q       <= root_d;
      odd_q        <= odd_d;
      inc_q        <= inc_d;
      busy_q       <= busy_d;
      prev_stage_q <= stage;
    end
  end
`ifdef UNION_FIND_VERTEX_ROOT_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
  always_comb
    cnt_d = (stage == ST_LOAD) ? 8'd0 :
            (stage == ST_MERGE && root_d != root_q && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
  assign root_change_count = cnt_q;
`endif
  assign neighbor_increase = inc_q;
  assign old_root_out      = root_q;
  assign root              = root_q;
  assign is_odd_cluster    = odd_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_union_find_vertex.sv
// tb_union_find_vertex: scoreboard bench for union_find_vertex (ADDRESS=5); count check uses a second instance when UNION_FIND_VERTEX_ROOT_COUNT_EN is defined
module tb_union_find_vertex;
  typedef struct {
    string      name;
    int         due;
    bit         is_cnt;
    logic [11:0] root;
    logic       odd;
    logic [3:0] inc;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1, measurement = 1'b0;
  logic [2:0]  stage = 3'd0;
  logic [3:0]  fg = '0, nodd = '0;
  logic [47:0] nroot = '0;
  logic [3:0]  inc;
  logic [11:0] old_root, root;
  logic        odd, busy;
  int          cyc = 0, errors = 0, checks = 0;
  exp_t        q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  union_find_vertex #(.ADDRESS_WIDTH(12), .NEIGHBOR_COUNT(4), .ADDRESS(5)) dut (
    .clk(clk), .reset(reset), .stage(stage), .measurement(measurement),
    .neighbor_fully_grown(fg), .neighbor_old_root(nroot), .neighbor_is_odd_cluster(nodd),
    .neighbor_increase(inc), .old_root_out(old_root), .is_odd_cluster(odd), .root(root), .busy(busy)
`ifdef UNION_FIND_VERTEX_ROOT_COUNT_EN
    , .root_change_count()
`endif
  );
`ifdef UNION_FIND_VERTEX_ROOT_COUNT_EN
  logic [3:0]  inc2;
  logic [11:0] old_root2, root2;
  logic        odd2, busy2;
  logic [7:0]  cnt2;
  union_find_vertex #(.ADDRESS_WIDTH(12), .NEIGHBOR_COUNT(4), .ADDRESS(4095)) dut2 (
    .clk(clk), .reset(reset), .stage(stage), .measurement(measurement),
    .neighbor_fully_grown(fg), .neighbor_old_root(nroot), .neighbor_is_odd_cluster(nodd),
    .neighbor_increase(inc2), .old_root_out(old_root2), .is_odd_cluster(odd2), .root(root2), .busy(busy2),
    .root_change_count(cnt2)
  );
`endif
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_out(input string name, input int off, input logic [11:0] r, input logic o,
                            input logic [3:0] i, input logic b);
    exp_t e;
    e.name = name; e.due = cyc + off; e.is_cnt = 1'b0;
    e.root = r; e.odd = o; e.inc = i; e.busy = b; e.cnt = '0;
    q.push_back(e);
  endtask
  task automatic expect_cnt(input string name, input int off, input logic [7:0] c);
    exp_t e;
    e.name = name; e.due = cyc + off; e.is_cnt = 1'b1;
    e.root = '0; e.odd = 1'b0; e.inc = '0; e.busy = 1'b0; e.cnt = c;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL %s: expectation missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end else if (e.is_cnt) begin
`ifdef UNION_FIND_VERTEX_ROOT_COUNT_EN
        if (cnt2 !== e.cnt) begin
          errors++;
          $display("FAIL %s: count got %0d want %0d", e.name, cnt2, e.cnt);
        end
`endif
      end else if ({root, old_root, odd, inc, busy} !== {e.root, e.root, e.odd, e.inc, e.busy}) begin
        errors++;
        $display("FAIL %s: got root=%0d old_root=%0d odd=%b inc=%b busy=%b want root=%0d odd=%b inc=%b busy=%b",
                 e.name, root, old_root, odd, inc, busy, e.root, e.odd, e.inc, e.busy);
      end
    end
  end
  initial begin
    step(2);
    expect_out("reset", 0, 12'd5, 1'b0, 4'b0000, 1'b0);
    step();
    reset = 1'b0;
    stage = 3'd1; measurement = 1'b1;
    expect_out("load", 1, 12'd5, 1'b1, 4'b0000, 1'b0);
    step();
    stage = 3'd0; measurement = 1'b0;
    expect_out("idle_hold", 1, 12'd5, 1'b1, 4'b0000, 1'b0);
    step();
    stage = 3'd2; fg = 4'b0010;
    expect_out("grow_pulse", 1, 12'd5, 1'b1, 4'b1101, 1'b0);
    expect_out("grow_c2", 2, 12'd5, 1'b1, 4'b0000, 1'b0);
    expect_out("grow_c3", 3, 12'd5, 1'b1, 4'b0000, 1'b0);
    expect_out("grow_c4", 4, 12'd5, 1'b1, 4'b0000, 1'b0);
    step(4);
    stage = 3'd0;
    expect_out("grow_exit", 1, 12'd5, 1'b1, 4'b0000, 1'b0);
    step();
    stage = 3'd2;
    expect_out("grow_pulse2", 1, 12'd5, 1'b1, 4'b1101, 1'b0);
    expect_out("grow_after2", 2, 12'd5, 1'b1, 4'b0000, 1'b0);
    step(2);
    stage = 3'd3; fg = 4'b0101; nroot = {12'd9, 12'd7, 12'd3, 12'd2};
    expect_out("merge_min", 1, 12'd2, 1'b1, 4'b0000, 1'b1);
    expect_out("merge_settle", 2, 12'd2, 1'b1, 4'b0000, 1'b0);
    step(2);
    stage = 3'd1; measurement = 1'b0;
    expect_out("reload_even", 1, 12'd5, 1'b0, 4'b0000, 1'b0);
    step();
    stage = 3'd3; fg = 4'b0010; nodd = 4'b0010; nroot = {12'd1, 12'd1, 12'd8, 12'd1};
    expect_out("merge_odd", 1, 12'd5, 1'b1, 4'b0000, 1'b1);
    expect_out("merge_odd_settle", 2, 12'd5, 1'b1, 4'b0000, 1'b0);
    step(2);
    fg = 4'b0101; nodd = 4'b0000; nroot = {12'd9, 12'd7, 12'd3, 12'd2};
    expect_out("merge_pre_reset", 1, 12'd2, 1'b1, 4'b0000, 1'b1);
    step(2);
    reset = 1'b1;
    expect_out("async_reset", 0, 12'd5, 1'b0, 4'b0000, 1'b0);
    step();
    reset = 1'b0; stage = 3'd1; measurement = 1'b1;
    step();
    stage = 3'd3;
    expect_out("merge_again", 1, 12'd2, 1'b1, 4'b0000, 1'b1);
    step();
    stage = 3'd6; fg = 4'b1111; nroot = '0; nodd = 4'b1111;
    expect_out("reserved_hold", 1, 12'd2, 1'b1, 4'b0000, 1'b0);
    expect_out("reserved_hold2", 2, 12'd2, 1'b1, 4'b0000, 1'b0);
    step(2);
    stage = 3'd0; fg = '0; nodd = '0;
`ifdef UNION_FIND_VERTEX_ROOT_COUNT_EN
    stage = 3'd1;
    step();
    stage = 3'd3; fg = 4'b0001;
    for (int k = 0; k < 300; k++) begin
      nroot = {36'd0, 12'(4094 - k)};
      step();
    end
    stage = 3'd0;
    expect_cnt("count_saturate", 0, 8'd255);
    step();
    stage = 3'd1;
    expect_cnt("count_clear", 1, 8'd0);
    step();
    stage = 3'd0;
`endif
    step(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation never checked (due cycle %0d)", e.name, e.due);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
